// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx
// Accepts a WIDTH-bit word through a valid/ready handshake and sends it on a
// single idle-high line as: start bit (0), data bits LSB first, stop bit (1).
// Each bit is held for CLKS_PER_BIT enabled clocks.
//
// Optional feature: define NIBBLE_SERIAL_TX_PARITY_EN to insert an even-parity
// bit (XOR of the latched word) between the last data bit and the stop bit.
//
// state  | meaning
// IDLE   | line high, ready to accept a word
// START  | driving the start bit (0)
// DATA   | driving data bits, LSB first
// PARITY | driving the even-parity bit (parity build only)
// STOP   | driving the stop bit (1); done on its last clock
module nibble_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  // Counter widths kept at least one bit so WIDTH=1 / CLKS_PER_BIT=1 still elaborate.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             sout_q;
  logic             bit_end;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  assign shreg_nxt = shreg >> 1;
  // With CLKS_PER_BIT=1 DIV_LAST is 0, so every enabled cycle ends a bit.
  assign bit_end   = (div_cnt == DIV_LAST);

  // Frame sequencer: advances only on enabled cycles; sout is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      shreg   <= '0;
      sout_q  <= 1'b1;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        S_IDLE: begin
          sout_q <= 1'b1;
          if (din_valid) begin
            shreg   <= din;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
            par_q   <= ^din;
`endif
            bit_cnt <= '0;
            div_cnt <= '0;
            sout_q  <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_cnt <= '0;
            sout_q  <= shreg[0];
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            shreg   <= shreg_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
              sout_q  <= par_q;
              state   <= S_PARITY;
`else
              sout_q  <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sout_q  <= shreg_nxt[0];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            sout_q  <= 1'b1;
            state   <= S_STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            sout_q  <= 1'b1;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          sout_q  <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and done are decoded from registered state; gating by en means a
  // done held off by en=0 reappears as soon as en returns.
  assign din_ready = en && !rst && (state == S_IDLE);
  assign done      = en && !rst && (state == S_STOP) && bit_end;
  assign busy      = (state != S_IDLE);
  assign sout      = sout_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: two instances (CLKS_PER_BIT=2 and 1) share the
// stimulus; a frame-position model checks every output every cycle, and
// directed frames are compared against hand-written waveforms.
module tb_nibble_serial_tx;
  localparam int W  = 4;
  localparam int C0 = 2;
  localparam int C1 = 1;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FL  = NB * C0;
  localparam int FL1 = NB * C1;

  logic         clk = 1'b0;
  logic         rst, en, din_valid;
  logic [W-1:0] din;
  logic         rdy0, sout0, busy0, done0;
  logic         rdy1, sout1, busy1, done1;

  nibble_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C0)) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .sout(sout0), .busy(busy0), .done(done0));

  nibble_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C1)) u1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sout(sout1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // ---------------- model: position within the frame per instance
  int         mpos [2] = '{-1, -1};
  logic [W-1:0] mword [2];
  bit         mvalid = 1'b0;

  function automatic int cpb(input int i);
    return (i == 0) ? C0 : C1;
  endfunction

  // Line level for bit slot b of a frame carrying word w.
  function automatic logic level(input logic [W-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    if (b == W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // f: 0 sout, 1 busy, 2 done, 3 din_ready
  function automatic logic exp_o(input int i, input int f);
    bit idle;
    idle = (mpos[i] < 0);
    case (f)
      0: return idle ? 1'b1 : level(mword[i], mpos[i] / cpb(i));
      1: return !idle;
      2: return !idle && en && !rst && (mpos[i] == NB * cpb(i) - 1);
      default: return idle && en && !rst;
    endcase
  endfunction

  function automatic logic act_o(input int i, input int f);
    case (f)
      0: return (i == 0) ? sout0 : sout1;
      1: return (i == 0) ? busy0 : busy1;
      2: return (i == 0) ? done0 : done1;
      default: return (i == 0) ? rdy0 : rdy1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) mvalid <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) mpos[i] <= -1;
      else if (en) begin
        if (mpos[i] < 0) begin
          if (din_valid) begin
            mword[i] <= din;
            mpos[i]  <= 0;
          end
        end else if (mpos[i] == NB * cpb(i) - 1) mpos[i] <= -1;
        else mpos[i] <= mpos[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_u%0d_sout", i),  act_o(i, 0), exp_o(i, 0));
        chk($sformatf("model_u%0d_busy", i),  act_o(i, 1), exp_o(i, 1));
        chk($sformatf("model_u%0d_done", i),  act_o(i, 2), exp_o(i, 2));
        chk($sformatf("model_u%0d_ready", i), act_o(i, 3), exp_o(i, 3));
      end
    end
  end

  // ---------------- directed stimulus with recorded waveforms
  logic s [0:63], d [0:63], r [0:63], bz [0:63], s1 [0:63], d1 [0:63];
  logic [0:FL-1]  e_f1, e_f2, e_0110;
  logic [0:FL1-1] e_c1;

  task automatic rec(input int k);
    s[k] = sout0; d[k] = done0; r[k] = rdy0; bz[k] = busy0;
    s1[k] = sout1; d1[k] = done1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Word offered in period 0 only; en low for off_len periods from off_from;
  // rst high in period rst_at. din is scrambled after acceptance.
  task automatic run(input logic [W-1:0] w, input int off_from, input int off_len,
                     input int rst_at, input int n);
    din = w; din_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      en  = !(k >= off_from && k < off_from + off_len);
      rst = (k == rst_at);
      @(negedge clk); rec(k);
      @(posedge clk); #1;
      din_valid = 1'b0; din = ~w;
    end
    en = 1'b1; rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    e_f1   = 14'b00111100111111;
    e_f2   = 14'b00000011001111;
    e_0110 = 14'b00001111000011;
    e_c1   = 7'b0110111;
`else
    e_f1   = 12'b001111001111;
    e_f2   = 12'b000000110011;
    e_0110 = 12'b000011110011;
    e_c1   = 6'b011011;
`endif
    rst = 1'b1; en = 1'b1; din_valid = 1'b0; din = '0;

    // reset held three cycles
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_sout", sout0, 1'b1);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", rdy0, 1'b1);
    chk("rel_sout", sout0, 1'b1);
    idle(1);

    // back-to-back: 1011 then 0100 with din_valid held
    din = 4'b1011; din_valid = 1'b1;
    for (int k = 0; k <= 2 * FL + 1; k++) begin
      @(negedge clk); rec(k);
      @(posedge clk); #1;
      if (k == 0) din = 4'b0100;
      if (k + 1 == FL + 2) din_valid = 1'b0;
    end
    chk("f1_ready_accept", r[0], 1'b1);
    for (int k = 1; k <= FL; k++) begin
      chk($sformatf("f1_sout_%0d", k), s[k], e_f1[k-1]);
      chk($sformatf("f1_done_%0d", k), d[k], k == FL);
    end
    chk("f1_ready_last", r[FL], 1'b0);
    chk("f1_ready_after", r[FL+1], 1'b1);
    chk("gap_sout", s[FL+1], 1'b1);
    chk("gap_busy", bz[FL+1], 1'b0);
    for (int j = 1; j <= FL; j++)
      chk($sformatf("f2_sout_%0d", FL + 1 + j), s[FL+1+j], e_f2[j-1]);
    chk("f2_done", d[2*FL+1], 1'b1);
    for (int k = 1; k <= FL1; k++)
      chk($sformatf("c1_sout_%0d", k), s1[k], e_c1[k-1]);
    chk("c1_done", d1[FL1], 1'b1);
    chk("c1_done_early", d1[FL1-1], 1'b0);
    idle(2);

    // en low for periods 5..7: frame stretched by three cycles
    run(4'b1011, 5, 3, -1, FL + 6);
    for (int k = 1; k <= FL + 3; k++)
      chk($sformatf("frz_sout_%0d", k), s[k],
          (k <= 5) ? e_f1[k-1] : (k <= 8) ? e_f1[4] : e_f1[k-4]);
    for (int k = 1; k <= FL + 4; k++)
      chk($sformatf("frz_done_%0d", k), d[k], k == FL + 3);
    chk("frz_ready", r[6], 1'b0);
    idle(2);

    // en low over the done cycle: done re-issued after en returns
    run(4'b0110, FL, 2, -1, FL + 5);
    for (int k = 1; k < FL; k++)
      chk($sformatf("hold_sout_%0d", k), s[k], e_0110[k-1]);
    chk("hold_done_a", d[FL], 1'b0);
    chk("hold_done_b", d[FL+1], 1'b0);
    chk("hold_done_c", d[FL+2], 1'b1);
    chk("hold_done_d", d[FL+3], 1'b0);
    chk("hold_busy", bz[FL+3], 1'b0);
    idle(2);

    // rst at period 6 aborts the frame
    run(4'b1011, 99, 0, 6, FL + 2);
    chk("abort_ready_rst", r[6], 1'b0);
    chk("abort_sout", s[7], 1'b1);
    chk("abort_busy", bz[7], 1'b0);
    chk("abort_ready", r[7], 1'b1);
    for (int k = 0; k < FL + 2; k++)
      chk($sformatf("abort_done_%0d", k), d[k], 1'b0);
    run(4'b0110, 99, 0, -1, FL + 2);
    for (int k = 1; k <= FL; k++)
      chk($sformatf("after_sout_%0d", k), s[k], e_0110[k-1]);
    chk("after_done", d[FL], 1'b1);
    idle(2);

    // rst and din_valid together: nothing accepted
    rst = 1'b1; din_valid = 1'b1; din = 4'b1111;
    @(negedge clk);
    chk("rstv_ready", rdy0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("rstv_busy", busy0, 1'b0);
    chk("rstv_sout", sout0, 1'b1);

    // en low while idle with din_valid: nothing accepted
    en = 1'b0; din_valid = 1'b1;
    idle(2);
    en = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    chk("en_idle_busy", busy0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
